// File: rtl/fetch_queue.sv
// fetch_queue: in-order fetch-to-decode FIFO with flush; FETCH_QUEUE_BYPASS_EN adds a zero-latency path when empty.
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif

module fetch_queue #(
   parameter int PC_W    = `PC_SIZE,
   parameter int INSTR_W = `INSTR_SIZE,
   parameter int DEPTH   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               if_valid,
   input  logic [PC_W-1:0]    if_pc,
   input  logic [INSTR_W-1:0] if_instr,
   input  logic               if_take,
   output logic               if_ready,
   output logic               id_valid,
   output logic [PC_W-1:0]    id_pc,
   output logic [INSTR_W-1:0] id_instr,
   output logic               id_take,
   input  logic               id_ready
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = DEPTH[AW:0];
   logic [PC_W-1:0]    pc_mem    [DEPTH];
   logic [INSTR_W-1:0] instr_mem [DEPTH];
   logic               take_mem  [DEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [AW:0]        count;
   logic               empty, push, pop;
   assign empty    = count == '0;
   assign if_ready = count != FULL;
`ifdef FETCH_QUEUE_BYPASS_EN
   logic byp;
   // Empty queue: the fetch entry goes straight to decode and is stored only if decode stalls.
   assign byp      = empty & if_valid & ~flush;
   assign push     = if_valid & if_ready & ~flush & ~(byp & id_ready);
   assign pop      = ~empty & id_ready & ~flush;
   assign id_valid = ~empty | byp;
   assign id_pc    = byp ? if_pc : pc_mem[rd_ptr];
   assign id_instr = byp ? if_instr : instr_mem[rd_ptr];
   assign id_take  = byp ? if_take : take_mem[rd_ptr];
`else
   assign push     = if_valid & if_ready & ~flush;
   assign pop      = id_valid & id_ready & ~flush;
   assign id_valid = ~empty;
   assign id_pc    = pc_mem[rd_ptr];
   assign id_instr = instr_mem[rd_ptr];
   assign id_take  = take_mem[rd_ptr];
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]    <= '0;
            instr_mem[i] <= '0;
            take_mem[i]  <= 1'b0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            pc_mem[wr_ptr]    <= if_pc;
            instr_mem[wr_ptr] <= if_instr;
            take_mem[wr_ptr]  <= if_take;
            wr_ptr            <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop) count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized checks of fetch_queue against a queue-based reference model.
module tb_fetch_queue;
   localparam int D = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   typedef struct {logic [31:0] pc; logic [31:0] instr; logic take;} ent_t;
   logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
   logic        if_valid = 1'b0, if_take = 1'b0, id_ready = 1'b0;
   logic [31:0] if_pc = '0, if_instr = '0;
   logic        if_ready, id_valid, id_take;
   logic [31:0] id_pc, id_instr;
   ent_t        q[$];
   int          n_chk = 0, n_fail = 0;

   fetch_queue #(.PC_W(32), .INSTR_W(32), .DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_take(if_take),
      .if_ready(if_ready),
      .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_take(id_take),
      .id_ready(id_ready)
   );

   always #5 clk = ~clk;

   function automatic bit m_valid();
      return q.size() != 0 || (BYP && if_valid && !flush);
   endfunction

   function automatic ent_t m_head();
      ent_t e;
      if (q.size() != 0) return q[0];
      e.pc = if_pc; e.instr = if_instr; e.take = if_take;
      return e;
   endfunction

   task automatic drive(input logic v, input logic [31:0] pc, input logic tk, input logic rdy, input logic fl);
      if_valid = v; if_pc = pc; if_instr = pc ^ 32'hA5A5_0000; if_take = tk;
      id_ready = rdy; flush = fl;
      #1;
   endtask

   // Advance the model by the queue rules, then clock the DUT.
   task automatic tick();
      ent_t e;
      bit acc, dq;
      e.pc = if_pc; e.instr = if_instr; e.take = if_take;
      if (flush) q.delete();
      else if (BYP && q.size() == 0 && if_valid) begin
         if (!id_ready) q.push_back(e);
      end else begin
         acc = if_valid && q.size() != D;
         dq  = q.size() != 0 && id_ready;
         if (dq) void'(q.pop_front());
         if (acc) q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_chk++; if (id_valid !== 1'b0 || if_ready !== 1'b1) begin n_fail++; $display("FAIL reset_init: valid=%b ready=%b want 0/1", id_valid, if_ready); end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin drive(1'b1, 32'h10 + 4 * i, 1'b1, 1'b0, 1'b0); tick(); end
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h10) begin n_fail++; $display("FAIL reset_prefill: valid=%b pc=%h want 1/00000010", id_valid, id_pc); end
      #2 rst_n = 1'b0;
      #1;
      q.delete();
      n_chk++; if (id_valid !== 1'b0 || if_ready !== 1'b1) begin n_fail++; $display("FAIL reset_async: valid=%b ready=%b want 0/1", id_valid, if_ready); end
      n_chk++; if (id_pc !== 32'h0 || id_instr !== 32'h0 || id_take !== 1'b0) begin n_fail++; $display("FAIL reset_fields: pc=%h instr=%h take=%b want 0", id_pc, id_instr, id_take); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin n_fail++; $display("FAIL reset_head: valid=%b pc=%h want 1/00000100", id_valid, id_pc); end
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1); tick();
   endtask

   logic take_rec [4];

   task automatic test_fill_stall();
      for (int i = 0; i < 4; i++) begin
         take_rec[i] = 1'($urandom_range(0, 1));
         drive(1'b1, 32'(4 * i), take_rec[i], 1'b0, 1'b0);
         n_chk++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready%0d: got %b want 1", i, if_ready); end
         tick();
      end
      drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
      n_chk++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: if_ready=%b want 0", if_ready); end
      tick();
      n_chk++; if (id_pc !== 32'h0 || id_valid !== 1'b1) begin n_fail++; $display("FAIL fill_head: pc=%h valid=%b want 00000000/1", id_pc, id_valid); end
      n_chk++; if (q.size() != 4 || if_ready !== 1'b0) begin n_fail++; $display("FAIL fill_reject: model=%0d if_ready=%b want 4/0", q.size(), if_ready); end
   endtask

   task automatic test_drain();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
         n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'(4 * i) || id_take !== take_rec[i]) begin
            n_fail++; $display("FAIL drain%0d: valid=%b pc=%h take=%b want 1/%h/%b", i, id_valid, id_pc, id_take, 32'(4 * i), take_rec[i]);
         end
         n_chk++; if (id_instr !== (32'(4 * i) ^ 32'hA5A5_0000)) begin n_fail++; $display("FAIL drain_instr%0d: got %h", i, id_instr); end
         tick();
         n_chk++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready%0d: got %b want 1", i, if_ready); end
      end
      n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: id_valid=%b want 0", id_valid); end
   endtask

   task automatic test_stream();
      for (int i = 0; i < 2; i++) begin drive(1'b1, 32'h200 + 4 * i, 1'(i), 1'b0, 1'b0); tick(); end
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 32'h208 + 4 * i, 1'(i), 1'b1, 1'b0);
         n_chk++; if (id_valid !== 1'b1 || if_ready !== 1'b1 || id_pc !== 32'h200 + 4 * i) begin
            n_fail++; $display("FAIL stream%0d: valid=%b ready=%b pc=%h want 1/1/%h", i, id_valid, if_ready, id_pc, 32'h200 + 4 * i);
         end
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
         n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h228 + 4 * i) begin n_fail++; $display("FAIL stream_tail%0d: valid=%b pc=%h want 1/%h", i, id_valid, id_pc, 32'h228 + 4 * i); end
         tick();
      end
      n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL stream_count: id_valid=%b want 0", id_valid); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin drive(1'b1, 32'h300 + 4 * i, 1'b0, 1'b0, 1'b0); tick(); end
      drive(1'b1, 32'hDEAD, 1'b1, 1'b1, 1'b1);
      tick();
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
      n_chk++; if (id_valid !== 1'b0 || if_ready !== 1'b1) begin n_fail++; $display("FAIL flush_next: valid=%b ready=%b want 0/1", id_valid, if_ready); end
      tick();
      n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost: id_valid=%b pc=%h want 0", id_valid, id_pc); end
   endtask

   task automatic test_bypass();
      drive(1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
      n_chk++; if (id_valid !== BYP) begin n_fail++; $display("FAIL bypass_valid: got %b want %b", id_valid, BYP); end
      if (BYP) begin
         n_chk++; if (id_pc !== 32'h40 || id_take !== 1'b1) begin n_fail++; $display("FAIL bypass_pc: pc=%h take=%b want 00000040/1", id_pc, id_take); end
      end
      tick();
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
      n_chk++; if (id_valid !== !BYP) begin n_fail++; $display("FAIL bypass_next_valid: got %b want %b", id_valid, !BYP); end
      if (!BYP) begin
         n_chk++; if (id_pc !== 32'h40) begin n_fail++; $display("FAIL bypass_next_pc: got %h want 00000040", id_pc); end
      end
      tick();
      n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_empty: id_valid=%b want 0", id_valid); end
   endtask

   task automatic test_random();
      ent_t e;
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 29) == 0));
         e = m_head();
         n_chk++; if (id_valid !== m_valid() || if_ready !== (q.size() != D)) begin
            n_fail++; $display("FAIL rand%0d_flags: valid=%b ready=%b want %b/%b", i, id_valid, if_ready, m_valid(), q.size() != D);
         end
         if (m_valid()) begin
            n_chk++; if (id_pc !== e.pc || id_instr !== e.instr || id_take !== e.take) begin
               n_fail++; $display("FAIL rand%0d_head: pc=%h instr=%h take=%b want %h/%h/%b", i, id_pc, id_instr, id_take, e.pc, e.instr, e.take);
            end
         end
         tick();
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_fill_stall();
      test_drain();
      test_stream();
      test_flush();
      test_bypass();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
